btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Front-end input stage for the countdown-timer game: takes the raw, asynchronous, bouncing `btnS`/`btnU`/`btnD` pushbuttons and delivers clean single-cycle command pulses to the game core. Each button is synchronised, debounced and edge-detected. Up/down also auto-repeat while held, so the timer preset can be slewed quickly. The game core consumes only the `*_pulse` outputs and never sees raw button levels.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- `REPEAT_DELAY`, default 50_000_000: hold cycles from the first pulse to the first auto-repeat pulse (500 ms).
- `REPEAT_RATE`, default 10_000_000: cycles between subsequent auto-repeat pulses (100 ms).
- `Clk100Mhz  in  1`: the single clock; all state on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `btnS  in  1`: raw start/stop button, asynchronous.
- `btnU  in  1`: raw up button, asynchronous.
- `btnD  in  1`: raw down button, asynchronous.
- `start_pulse  out  1`: one-cycle pulse per accepted `btnS` press; never repeats.
- `up_pulse  out  1`: one-cycle pulse on an accepted `btnU` press, plus auto-repeats.
- `down_pulse  out  1`: one-cycle pulse on an accepted `btnD` press, plus auto-repeats.
- `btn_level  out  3`: debounced levels {S,U,D}, for status display.

## Operation
- Per button: 2-FF synchroniser → debounce counter → stable level → press FSM.
- Debounce:
  - Counter clears whenever the synchronised input equals the stable level.
  - Otherwise it increments each cycle.
  - When the input has differed for DEBOUNCE_CYCLES consecutive cycles, the stable level takes the input value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable level.
- Press FSM states: IDLE, HELD, REPEAT.
  - IDLE → HELD on stable rise: pulse issued, hold counter loaded.
  - HELD → REPEAT once the counter has run REPEAT_DELAY cycles: pulse issued, counter reloaded.
  - In REPEAT, a pulse is issued every REPEAT_RATE cycles.
  - Any state → IDLE on stable fall: no pulse, counter cleared.
- `btnS` instance has repeat disabled. It stays in HELD until release.
- Up/down conflict: while both U and D stable levels are high, `up_pulse` and `down_pulse` are forced to 0. The FSMs keep running, so the pulses resume after one button is released.
- Counter widths: `$clog2(param+1)` bits. Counters saturate and never wrap.
- Reset (async assert, sync release through the flops):
  - All synchronisers, stable levels and counters go to 0.
  - FSMs go to IDLE.
  - All outputs are 0.
  - A button held through reset release must debounce fresh before it produces a pulse.

## Timing
- Press latency: input first sampled high at edge N with no bounce → pulse high during cycle N+DEBOUNCE_CYCLES+3 (2 synchroniser + DEBOUNCE_CYCLES + 1 registered output).
- Release latency: stable level falls at edge N+DEBOUNCE_CYCLES+2. No output pulse.
- First repeat: REPEAT_DELAY cycles after the initial pulse. Later repeats: every REPEAT_RATE cycles.
- All outputs are registered. Pulses are exactly 1 cycle wide.
- Reset asserted mid-hold: outputs drop asynchronously. No pulse follows reset release unless the button is re-debounced.

## Structure
- Shared package `game_pkg`:
  - press FSM state enum {IDLE, HELD, REPEAT}
  - button index constants BTN_S=2, BTN_U=1, BTN_D=0
  - default timing constants
- Sub-module `btn_channel` (params DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE, REPEAT_EN) contains the synchroniser, debouncer and press FSM.
- `btn_conditioner` instantiates `btn_channel` three times and adds the up/down conflict mask.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset: hold `rst_n`=0 with all buttons high → all outputs 0. Release reset with buttons still high → first `start_pulse` exactly 7 cycles later.
- Clean press: `btnU` rises at edge 10 and is held 10 cycles → single `up_pulse` at cycle 17. `btn_level[1]`=1 from edge 16.
- Bounce: `btnS` toggles every 2 cycles for 20 cycles, then settles high → no pulse during the bounce, exactly one `start_pulse` 7 cycles after settling.
- Auto-repeat: hold `btnD` for 60 cycles → `down_pulse` at t0, t0+20, t0+25, t0+30, … Releasing stops pulses within 6 cycles. `btnS` held for 60 cycles → exactly one `start_pulse`.
- Conflict: hold U, then press D → after D debounces, neither `up_pulse` nor `down_pulse` fires. Release D → `up_pulse` resumes on its next repeat slot.
- Mid-operation reset: assert `rst_n` during REPEAT → outputs 0 immediately. No pulse in the 6 cycles after release, then a fresh initial pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the countdown-timer game front end:
// press FSM states, button indices and default timing constants.
package game_pkg;

    // Press FSM states, one FSM per button channel
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } press_state_t;

    // Bit positions of each button in the {S,U,D} level vector
    localparam int unsigned BTN_S = 2;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_D = 0;

    // Default timing at 100 MHz: 10 ms debounce, 500 ms first repeat, 100 ms repeat rate
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_RATE     = 10_000_000;

    // Bits needed to hold the values 0..n, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton channel: 2-FF synchroniser, debounce counter producing a
// stable level, and a press FSM that requests single-cycle pulses on a new
// press and (optionally) on auto-repeat while held. The pulse request is
// combinational; the parent registers it together with its masking.
module btn_channel
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse_req
);

    localparam int unsigned DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HW       = cnt_width(HOLD_MAX);

    localparam logic [DW-1:0] DB_LIMIT   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] DELAY_FIRE = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] DELAY_SAT  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] RATE_FIRE  = HW'(REPEAT_RATE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [DW-1:0] r_db_cnt;

    press_state_t  r_state;
    press_state_t  w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_pulse;

    // Two-flop synchroniser for the asynchronous raw button
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level only after it has differed from the stable
    // level on DEBOUNCE_CYCLES+1 consecutive edges (counter reaches the limit,
    // then the next differing edge commits), so any shorter glitch is ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt >= DB_LIMIT) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
        end
    end

    // Press FSM next-state: pulse on press, then after REPEAT_DELAY, then every
    // REPEAT_RATE; any fall of the stable level returns to IDLE silently.
    // The hold counter counts up from zero and fires on the cycle before the
    // target count, which lands the pulse exactly on the target cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_pulse     = 1'b0;
        if (!r_stable) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = HELD;
                    w_hold_nxt  = '0;
                    w_pulse     = 1'b1;
                end
                HELD: begin
                    if (REPEAT_EN && (r_hold_cnt >= DELAY_FIRE)) begin
                        w_state_nxt = REPEAT;
                        w_hold_nxt  = '0;
                        w_pulse     = 1'b1;
                    end else if (r_hold_cnt < DELAY_SAT) begin
                        w_hold_nxt = r_hold_cnt + HW'(1);
                    end
                end
                REPEAT: begin
                    if (r_hold_cnt >= RATE_FIRE) begin
                        w_hold_nxt = '0;
                        w_pulse    = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // Press FSM state and hold counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign o_level     = r_stable;
    assign o_pulse_req = w_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton front end for the countdown-timer game: three conditioned
// channels (start without repeat, up/down with auto-repeat) and registered
// pulse outputs with up/down suppressed while both are held.
module btn_conditioner
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       Clk100Mhz,
    input  logic       rst_n,
    input  logic       btnS,
    input  logic       btnU,
    input  logic       btnD,
    output logic       start_pulse,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [2:0] btn_level
);

    logic [2:0] w_level;
    logic [2:0] w_req;
    logic       w_conflict;

    logic       r_start;
    logic       r_up;
    logic       r_down;

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE),
        .REPEAT_EN       (1'b0)
    ) u_chan_s (
        .i_clk       (Clk100Mhz),
        .i_rst_n     (rst_n),
        .i_btn       (btnS),
        .o_level     (w_level[BTN_S]),
        .o_pulse_req (w_req[BTN_S])
    );

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE),
        .REPEAT_EN       (1'b1)
    ) u_chan_u (
        .i_clk       (Clk100Mhz),
        .i_rst_n     (rst_n),
        .i_btn       (btnU),
        .o_level     (w_level[BTN_U]),
        .o_pulse_req (w_req[BTN_U])
    );

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE),
        .REPEAT_EN       (1'b1)
    ) u_chan_d (
        .i_clk       (Clk100Mhz),
        .i_rst_n     (rst_n),
        .i_btn       (btnD),
        .o_level     (w_level[BTN_D]),
        .o_pulse_req (w_req[BTN_D])
    );

    // Up and down together is ambiguous; the FSMs keep running underneath
    assign w_conflict = w_level[BTN_U] & w_level[BTN_D];

    // Registered pulse outputs with the up/down conflict mask applied
    always_ff @(posedge Clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_start <= w_req[BTN_S];
            r_up    <= w_req[BTN_U] & ~w_conflict;
            r_down  <= w_req[BTN_D] & ~w_conflict;
        end
    end

    assign start_pulse = r_start;
    assign up_pulse    = r_up;
    assign down_pulse  = r_down;
    assign btn_level   = w_level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_RATE=5. Stimulus pushes expected pulse cycles
// ({S,U,D} mask per cycle); a negedge monitor pops and compares.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnS = 1'b1;
    logic       btnU = 1'b1;
    logic       btnD = 1'b1;
    logic       start_pulse;
    logic       up_pulse;
    logic       down_pulse;
    logic [2:0] btn_level;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5)
    ) dut (
        .Clk100Mhz   (clk),
        .rst_n       (rst_n),
        .btnS        (btnS),
        .btnU        (btnU),
        .btnD        (btnD),
        .start_pulse (start_pulse),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .btn_level   (btn_level)
    );

    always #5 clk = ~clk;

    // cyc == number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] mask;
    } ev_t;
    ev_t q[$];

    int total = 0;
    int bad   = 0;

    task automatic exp_pulse(input int c, input logic [2:0] m);
        ev_t e;
        e.cyc  = c;
        e.mask = m;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s got=%0h need=%0h (t=%0t)", name, got, need, $time);
        end
    endtask

    // Monitor: any pulse activity or a due expectation produces a comparison
    always @(negedge clk) begin : mon
        logic [2:0] act;
        logic [2:0] exp_m;
        act = {start_pulse, up_pulse, down_pulse};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_pulse cyc=%0d got=none need=%b", q[0].cyc, q[0].mask);
            void'(q.pop_front());
        end
        exp_m = (q.size() > 0 && q[0].cyc == cyc) ? q[0].mask : 3'b000;
        if (act != 3'b000 || exp_m != 3'b000) begin
            total++;
            if (act !== exp_m) begin
                bad++;
                $display("FAIL pulse cyc=%0d got=%b need=%b", cyc, act, exp_m);
            end
            if (exp_m != 3'b000) void'(q.pop_front());
        end
    end

    initial begin
        int c;
        // Reset with all buttons held: outputs quiet, then fresh debounce
        tick(3);
        check("rst_pulses", {29'd0, start_pulse, up_pulse, down_pulse}, 32'd0);
        check("rst_level", {29'd0, btn_level}, 32'd0);
        rst_n = 1'b1;
        c = cyc;
        exp_pulse(c + 8, 3'b100);          // U and D both held: masked
        tick(10);
        check("rst_level_all", {29'd0, btn_level}, 32'd7);
        btnS = 1'b0; btnU = 1'b0; btnD = 1'b0;
        tick(15);
        check("rst_level_rel", {29'd0, btn_level}, 32'd0);

        // Clean up press held 10 cycles
        c = cyc;
        btnU = 1'b1;
        exp_pulse(c + 8, 3'b010);
        tick(6);
        check("clean_lvl_pre", {31'd0, btn_level[1]}, 32'd0);
        tick(1);
        check("clean_lvl_post", {31'd0, btn_level[1]}, 32'd1);
        tick(3);
        btnU = 1'b0;
        tick(15);

        // Bouncing start button, then settled high
        for (int i = 0; i < 10; i++) begin
            btnS = (i % 2 == 0);
            tick(2);
        end
        check("bounce_lvl", {31'd0, btn_level[2]}, 32'd0);
        c = cyc;
        btnS = 1'b1;
        exp_pulse(c + 8, 3'b100);
        tick(15);
        btnS = 1'b0;
        tick(15);

        // Auto-repeat on down, held 60 cycles
        c = cyc;
        btnD = 1'b1;
        exp_pulse(c + 8, 3'b001);
        for (int t = c + 28; t <= c + 67; t += 5) exp_pulse(t, 3'b001);
        tick(60);
        btnD = 1'b0;
        tick(20);
        check("rep_lvl_rel", {29'd0, btn_level}, 32'd0);

        // Start held 60 cycles: one pulse only
        c = cyc;
        btnS = 1'b1;
        exp_pulse(c + 8, 3'b100);
        tick(60);
        btnS = 1'b0;
        tick(15);

        // Conflict: U held, D pressed then released, then U released
        c = cyc;
        btnU = 1'b1;
        exp_pulse(c + 8,  3'b010);
        exp_pulse(c + 28, 3'b010);
        exp_pulse(c + 33, 3'b010);
        exp_pulse(c + 53, 3'b010);
        exp_pulse(c + 58, 3'b010);
        tick(30);
        btnD = 1'b1;
        tick(15);
        check("conf_lvl_both", {29'd0, btn_level}, 32'd3);
        btnD = 1'b0;
        tick(10);
        btnU = 1'b0;
        tick(20);

        // Reset in the middle of REPEAT, button held through release
        c = cyc;
        btnD = 1'b1;
        exp_pulse(c + 8,  3'b001);
        exp_pulse(c + 28, 3'b001);
        exp_pulse(c + 33, 3'b001);
        tick(38);
        check("midrst_pre", {31'd0, down_pulse}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out", {29'd0, start_pulse, up_pulse, down_pulse}, 32'd0);
        check("midrst_lvl", {29'd0, btn_level}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        c = cyc;
        exp_pulse(c + 8, 3'b001);
        tick(12);
        btnD = 1'b0;
        tick(15);

        tick(5);
        check("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
